// File: rtl/lbist_seq_ctrl_if.sv
// lbist_seq_ctrl_if: BIST handshake, wrapper control and response bus between controller (master) and lbist_seq_ctrl (slave); bist_abort_i exists with LBIST_ABORT_EN
interface lbist_seq_ctrl_if;
    logic        bist_start_i;
`ifdef LBIST_ABORT_EN
    logic        bist_abort_i;
`endif
    logic        test_mode_o;
    logic        core_rst_no;
    logic        fetch_enable_o;
    logic [31:0] pattern_o;
    logic        resp_valid_i;
    logic [31:0] resp_data_i;
    logic        bist_busy_o;
    logic        bist_done_o;
    logic        bist_pass_o;
    logic [31:0] signature_o;
    modport master (
        output bist_start_i, resp_valid_i, resp_data_i,
`ifdef LBIST_ABORT_EN
        output bist_abort_i,
`endif
        input test_mode_o, core_rst_no, fetch_enable_o, pattern_o,
        input bist_busy_o, bist_done_o, bist_pass_o, signature_o
    );
    modport slave (
        input bist_start_i, resp_valid_i, resp_data_i,
`ifdef LBIST_ABORT_EN
        input bist_abort_i,
`endif
        output test_mode_o, core_rst_no, fetch_enable_o, pattern_o,
        output bist_busy_o, bist_done_o, bist_pass_o, signature_o
    );
endinterface

// File: rtl/lbist_seq_ctrl.sv
// lbist_seq_ctrl: logic-BIST sequencer (clk_i, rst_ni, bus) driving wrapper test_mode/reset/fetch, LFSR stimulus and MISR golden check; optional abort via LBIST_ABORT_EN
module lbist_seq_ctrl #(
    parameter int          RESET_CYCLES = 8,
    parameter int          RUN_CYCLES   = 1024,
    parameter int          DRAIN_CYCLES = 4,
    parameter logic [31:0] LFSR_SEED    = 32'h0000_0001,
    parameter logic [31:0] LFSR_POLY    = 32'hA300_0000,
    parameter logic [31:0] MISR_POLY    = 32'h8020_0003,
    parameter logic [31:0] GOLDEN_SIG   = 32'h0000_0000
) (
    input logic             clk_i,
    input logic             rst_ni,
    lbist_seq_ctrl_if.slave bus
);
    localparam int RC = RESET_CYCLES > 0 ? RESET_CYCLES : 1;
    localparam int UC = RUN_CYCLES > 0 ? RUN_CYCLES : 1;
    localparam int DC = DRAIN_CYCLES > 0 ? DRAIN_CYCLES : 1;
    localparam int MC = RC > UC ? (RC > DC ? RC : DC) : (UC > DC ? UC : DC);
    localparam int CW = MC > 1 ? $clog2(MC) : 1;
    localparam logic [31:0] SEED = LFSR_SEED == '0 ? 32'h1 : LFSR_SEED;
    typedef enum logic [2:0] {IDLE, RST, RUN, DRAIN, DONE} state_t;
    state_t        state;
    logic [CW-1:0] cnt;
    logic [31:0]   lfsr, misr, lfsr_nxt, misr_nxt;
    logic          test_mode, core_rst_n, fetch, busy, done, pass;
    assign lfsr_nxt = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_POLY : '0);
    assign misr_nxt = (state == RUN || state == DRAIN) && bus.resp_valid_i
                    ? {1'b0, misr[31:1]} ^ (misr[0] ? MISR_POLY : '0) ^ bus.resp_data_i : misr;
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state      <= IDLE;
            cnt        <= '0;
            lfsr       <= SEED;
            misr       <= '0;
            test_mode  <= 1'b0;
            core_rst_n <= 1'b0;
            fetch      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
        end
`ifdef LBIST_ABORT_EN
        else if (bus.bist_abort_i && (state == RST || state == RUN || state == DRAIN)) begin
            state      <= IDLE;
            test_mode  <= 1'b1;
            core_rst_n <= 1'b0;
            fetch      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
        end
`endif
        else begin
            misr <= misr_nxt;
            case (state)
                IDLE: begin
                    if (bus.bist_start_i) begin
                        state      <= RST;
                        cnt        <= CW'(RC - 1);
                        lfsr       <= SEED;
                        misr       <= '0;
                        test_mode  <= 1'b1;
                        core_rst_n <= 1'b0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                    end else begin
                        test_mode  <= 1'b0;
                        core_rst_n <= 1'b1;
                        busy       <= 1'b0;
                    end
                    fetch <= 1'b0;
                end
                RST: begin
                    if (cnt == '0) begin
                        state      <= RUN;
                        cnt        <= CW'(UC - 1);
                        core_rst_n <= 1'b1;
                        fetch      <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RUN: begin
                    lfsr <= lfsr_nxt;
                    if (cnt == '0) begin
                        state <= DRAIN;
                        cnt   <= CW'(DC - 1);
                        fetch <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DRAIN: begin
                    if (cnt == '0) begin
                        state      <= DONE;
                        core_rst_n <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        pass       <= misr_nxt == GOLDEN_SIG;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (!bus.bist_start_i) begin
                        state      <= IDLE;
                        test_mode  <= 1'b0;
                        core_rst_n <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign bus.test_mode_o    = test_mode;
    assign bus.core_rst_no    = core_rst_n;
    assign bus.fetch_enable_o = fetch;
    assign bus.pattern_o      = lfsr;
    assign bus.bist_busy_o    = busy;
    assign bus.bist_done_o    = done;
    assign bus.bist_pass_o    = pass;
    assign bus.signature_o    = misr;
endmodule

// File: tb/tb_lbist_seq_ctrl.sv
// tb_lbist_seq_ctrl: randomized self-checking bench for lbist_seq_ctrl against a cycle-index reference model
module tb_lbist_seq_ctrl;
    localparam int RC = 2, RUNC = 4, DC = 1, N = RC + RUNC + DC;
    localparam logic [31:0] GA = 32'hB02C_0003;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;
    logic [31:0] pat_m = 32'h1;
    logic [31:0] sig_m = 32'h0;
    logic pass_ma = 1'b0;
    logic pass_mb = 1'b0;
    logic done_m = 1'b0;
    logic [31:0] run_pat [4] = '{32'h0000_0001, 32'hA300_0000, 32'h5180_0000, 32'h28C0_0000};
    logic [4:0] ctl_a;
    lbist_seq_ctrl_if ifa();
    lbist_seq_ctrl_if ifb();
    assign ifb.bist_start_i = ifa.bist_start_i;
    assign ifb.resp_valid_i = ifa.resp_valid_i;
    assign ifb.resp_data_i  = ifa.resp_data_i;
`ifdef LBIST_ABORT_EN
    assign ifb.bist_abort_i = ifa.bist_abort_i;
`endif
    assign ctl_a = {ifa.test_mode_o, ifa.core_rst_no, ifa.fetch_enable_o, ifa.bist_busy_o, ifa.bist_done_o};
    lbist_seq_ctrl #(.RESET_CYCLES(RC), .RUN_CYCLES(RUNC), .DRAIN_CYCLES(DC), .GOLDEN_SIG(GA))
        dut_a (.clk_i(clk), .rst_ni(rst_n), .bus(ifa));
    lbist_seq_ctrl #(.RESET_CYCLES(RC), .RUN_CYCLES(RUNC), .DRAIN_CYCLES(DC), .GOLDEN_SIG(32'h0))
        dut_b (.clk_i(clk), .rst_ni(rst_n), .bus(ifb));
    always #5 clk = ~clk;
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'hA300_0000 : 32'h0);
    endfunction
    function automatic logic [31:0] misr_step(input logic [31:0] m, input logic [31:0] d);
        return (m >> 1) ^ (m[0] ? 32'h8020_0003 : 32'h0) ^ d;
    endfunction
    function automatic logic [4:0] ctl(input int ph, input logic d);
        return ph == 1 ? 5'b10010 : ph == 2 ? 5'b11110 : ph == 3 ? 5'b11010 : ph == 4 ? 5'b10001 : {4'b0100, d};
    endfunction
    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (ctl_a !== 5'b00000) begin failures++; $display("FAIL reset_ctl: got %b want 00000", ctl_a); end
        checks++;
        if ({ifa.pattern_o, ifa.signature_o, ifa.bist_pass_o} !== {32'h1, 32'h0, 1'b0}) begin
            failures++; $display("FAIL reset_data: got pat=%h sig=%h pass=%b want 00000001 00000000 0", ifa.pattern_o, ifa.signature_o, ifa.bist_pass_o);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (ctl_a !== 5'b01000) begin failures++; $display("FAIL reset_release: got %b want 01000", ctl_a); end
        pat_m = 32'h1; sig_m = 32'h0; pass_ma = 1'b0; pass_mb = 1'b0; done_m = 1'b0;
    endtask
    // mode 0: random responses, 1: directed single-bit response, 2: responses only outside the window
    task automatic test_sequence(input int mode, input logic hold);
        int ph;
        logic v, ea, eb;
        logic [31:0] d;
        ifa.bist_start_i = 1'b1;
        pat_m = 32'h1; sig_m = 32'h0;
        for (int i = 1; i <= N + 1; i++) begin
            @(negedge clk);
            ph = i <= RC ? 1 : i <= RC + RUNC ? 2 : i <= N ? 3 : 4;
            ea = ph == 4 ? sig_m == GA : 1'b0;
            eb = ph == 4 ? sig_m == 32'h0 : 1'b0;
            checks++;
            if (ctl_a !== ctl(ph, 1'b0)) begin failures++; $display("FAIL seq_ctl c%0d: got %b want %b", i, ctl_a, ctl(ph, 1'b0)); end
            checks++;
            if (ifa.pattern_o !== pat_m) begin failures++; $display("FAIL seq_pattern c%0d: got %h want %h", i, ifa.pattern_o, pat_m); end
            checks++;
            if (ifa.signature_o !== sig_m) begin failures++; $display("FAIL seq_sig c%0d: got %h want %h", i, ifa.signature_o, sig_m); end
            checks++;
            if ({ifa.bist_pass_o, ifb.bist_pass_o} !== {ea, eb}) begin
                failures++; $display("FAIL seq_pass c%0d: got %b%b want %b%b", i, ifa.bist_pass_o, ifb.bist_pass_o, ea, eb);
            end
            if (mode == 1 && ph == 2) begin
                checks++;
                if (ifa.pattern_o !== run_pat[i-RC-1]) begin failures++; $display("FAIL run_pattern c%0d: got %h want %h", i, ifa.pattern_o, run_pat[i-RC-1]); end
            end
            if (mode == 1 && ph == 4) begin
                checks++;
                if (ifa.signature_o !== GA) begin failures++; $display("FAIL directed_sig: got %h want %h", ifa.signature_o, GA); end
            end
            if (ph == 4) begin pass_ma = ea; pass_mb = eb; end
            v = mode == 0 ? 1'($urandom) : mode == 1 ? 1'b1 : ph == 4;
            d = mode == 0 ? $urandom : mode == 1 ? (i == RC + 1 ? 32'h1 : 32'h0) : 32'hFFFF_FFFF;
            ifa.resp_valid_i = v;
            ifa.resp_data_i = d;
            ifa.bist_start_i = i == N + 1 ? hold : 1'($urandom);
            if ((ph == 2 || ph == 3) && v) sig_m = misr_step(sig_m, d);
            if (ph == 2) pat_m = lfsr_step(pat_m);
        end
        done_m = 1'b1;
        if (!hold) begin
            @(negedge clk);
            checks++;
            if (ctl_a !== ctl(0, 1'b1)) begin failures++; $display("FAIL done_to_idle: got %b want %b", ctl_a, ctl(0, 1'b1)); end
            checks++;
            if ({ifa.signature_o, ifa.bist_pass_o, ifb.bist_pass_o} !== {sig_m, pass_ma, pass_mb}) begin
                failures++; $display("FAIL idle_hold: got %h %b%b want %h %b%b", ifa.signature_o, ifa.bist_pass_o, ifb.bist_pass_o, sig_m, pass_ma, pass_mb);
            end
            ifa.resp_valid_i = 1'b0;
        end
    endtask
    task automatic test_ignore_resp;
        ifa.resp_valid_i = 1'b1;
        ifa.resp_data_i = 32'hFFFF_FFFF;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (ifa.signature_o !== sig_m) begin failures++; $display("FAIL idle_resp: got %h want %h", ifa.signature_o, sig_m); end
        end
        test_sequence(2, 1'b0);
        checks++;
        if ({ifa.signature_o, ifa.bist_pass_o, ifb.bist_pass_o} !== {32'h0, 2'b01}) begin
            failures++; $display("FAIL ignore_resp: got %h %b%b want 00000000 01", ifa.signature_o, ifa.bist_pass_o, ifb.bist_pass_o);
        end
    endtask
    task automatic test_restart;
        test_sequence(0, 1'b1);
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (ctl_a !== ctl(4, 1'b1)) begin failures++; $display("FAIL hold_done: got %b want %b", ctl_a, ctl(4, 1'b1)); end
        end
        ifa.bist_start_i = 1'b0;
        @(negedge clk);
        checks++;
        if ({ctl_a, ifa.signature_o} !== {ctl(0, 1'b1), sig_m}) begin
            failures++; $display("FAIL drop_start: got %b %h want %b %h", ctl_a, ifa.signature_o, ctl(0, 1'b1), sig_m);
        end
        test_sequence(0, 1'b0);
    endtask
    task automatic test_midrun_reset;
        ifa.bist_start_i = 1'b1;
        repeat (RC + 2) begin
            @(negedge clk);
            ifa.bist_start_i = 1'b0;
        end
        checks++;
        if (ctl_a !== ctl(2, 1'b0)) begin failures++; $display("FAIL midrun_pre: got %b want %b", ctl_a, ctl(2, 1'b0)); end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({ctl_a, ifa.pattern_o, ifa.signature_o, ifa.bist_pass_o} !== {5'b00000, 32'h1, 32'h0, 1'b0}) begin
            failures++; $display("FAIL midrun_reset: got %b %h %h %b want 00000 00000001 00000000 0", ctl_a, ifa.pattern_o, ifa.signature_o, ifa.bist_pass_o);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (ctl_a !== 5'b01000) begin failures++; $display("FAIL midrun_release: got %b want 01000", ctl_a); end
        sig_m = 32'h0; pat_m = 32'h1; pass_ma = 1'b0; pass_mb = 1'b0; done_m = 1'b0;
    endtask
`ifdef LBIST_ABORT_EN
    task automatic test_abort;
        logic [31:0] d;
        ifa.bist_abort_i = 1'b1;
        @(negedge clk);
        checks++;
        if (ctl_a !== ctl(0, done_m)) begin failures++; $display("FAIL abort_idle: got %b want %b", ctl_a, ctl(0, done_m)); end
        ifa.bist_abort_i = 1'b0;
        ifa.bist_start_i = 1'b1;
        sig_m = 32'h0;
        for (int i = 1; i <= RC + 2; i++) begin
            @(negedge clk);
            d = $urandom;
            ifa.resp_valid_i = 1'b1;
            ifa.resp_data_i = d;
            ifa.bist_start_i = 1'b0;
            ifa.bist_abort_i = i == RC + 2;
            if (i > RC && i < RC + 2) sig_m = misr_step(sig_m, d);
        end
        @(negedge clk);
        ifa.bist_abort_i = 1'b0;
        ifa.resp_valid_i = 1'b0;
        checks++;
        if ({ctl_a, ifa.signature_o, ifa.bist_pass_o} !== {5'b10000, sig_m, 1'b0}) begin
            failures++; $display("FAIL abort_cycle: got %b %h %b want 10000 %h 0", ctl_a, ifa.signature_o, ifa.bist_pass_o, sig_m);
        end
        @(negedge clk);
        checks++;
        if (ctl_a !== 5'b01000) begin failures++; $display("FAIL abort_idle_after: got %b want 01000", ctl_a); end
        done_m = 1'b0; pass_ma = 1'b0; pass_mb = 1'b0;
    endtask
`endif
    initial begin
        ifa.bist_start_i = 1'b0;
        ifa.resp_valid_i = 1'b0;
        ifa.resp_data_i = 32'h0;
`ifdef LBIST_ABORT_EN
        ifa.bist_abort_i = 1'b0;
`endif
        test_reset;
        test_sequence(1, 1'b0);
        repeat (4) test_sequence(0, 1'b0);
        test_ignore_resp;
        test_restart;
        test_midrun_reset;
`ifdef LBIST_ABORT_EN
        test_abort;
`endif
        test_sequence(1, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
